// File: rtl/rgb_led_pkg.sv
// Shared definitions for the RGB LED PWM controller: channel mode encoding
// and breathe-ramp direction.
package rgb_led_pkg;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_ON      = 2'd1,
        MODE_BLINK   = 2'd2,
        MODE_BREATHE = 2'd3
    } mode_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    // Width of a counter that must hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rgb_led_pwm_if.sv
// Register-strobe configuration bus and PWM outputs of the RGB LED controller.
interface rgb_led_pwm_if #(
    parameter int NUM_CH   = 3,
    parameter int PWM_BITS = 8
);
    import rgb_led_pkg::*;

    localparam int CH_W = cnt_width(NUM_CH);

    logic                cfg_we;
    logic [CH_W-1:0]     cfg_ch;
    mode_t               cfg_mode;
    logic [PWM_BITS-1:0] cfg_duty;
    logic [NUM_CH-1:0]   pwm;
    logic                period_start;

    modport master (
        output cfg_we, cfg_ch, cfg_mode, cfg_duty,
        input  pwm, period_start
    );

    modport slave (
        input  cfg_we, cfg_ch, cfg_mode, cfg_duty,
        output pwm, period_start
    );

endinterface

// File: rtl/rgb_pwm_channel.sv
// One PWM channel: config and period-aligned shadow registers, effective-duty
// selection by mode, and the registered compare output.
module rgb_pwm_channel
    import rgb_led_pkg::*;
#(
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                boundary_i,
    input  logic                we_i,
    input  mode_t               mode_i,
    input  logic [PWM_BITS-1:0] duty_i,
    input  logic [PWM_BITS-1:0] cnt_i,
    input  logic                blink_on_i,
    input  logic [PWM_BITS-1:0] level_i,
    output logic                pwm_o
);

    mode_t               mode_q, mode_d;
    mode_t               mode_s_q, mode_s_d;
    logic [PWM_BITS-1:0] duty_q, duty_d;
    logic [PWM_BITS-1:0] duty_s_q, duty_s_d;
    logic [PWM_BITS-1:0] eff;
    logic                pwm_q, pwm_d;

    // Shadows copy the next-state config so a write on the boundary is not lost.
    always_comb begin
        mode_d   = mode_q;
        duty_d   = duty_q;
        mode_s_d = mode_s_q;
        duty_s_d = duty_s_q;
        if (we_i) begin
            mode_d = mode_i;
            duty_d = duty_i;
        end
        if (boundary_i) begin
            mode_s_d = mode_d;
            duty_s_d = duty_d;
        end
    end

    always_comb begin
        eff = '0;
        case (mode_s_q)
            MODE_OFF:     eff = '0;
            MODE_ON:      eff = duty_s_q;
            MODE_BLINK:   eff = blink_on_i ? duty_s_q : '0;
            MODE_BREATHE: eff = (level_i < duty_s_q) ? level_i : duty_s_q;
            default:      eff = '0;
        endcase
        pwm_d = (cnt_i < eff);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q   <= MODE_OFF;
            duty_q   <= '0;
            mode_s_q <= MODE_OFF;
            duty_s_q <= '0;
            pwm_q    <= 1'b0;
        end else begin
            mode_q   <= mode_d;
            duty_q   <= duty_d;
            mode_s_q <= mode_s_d;
            duty_s_q <= duty_s_d;
            pwm_q    <= pwm_d;
        end
    end

    assign pwm_o = pwm_q;

endmodule

// File: rtl/rgb_led_pwm.sv
// Multi-channel LED brightness controller: shared PWM counter, blink and
// breathe generators, and one rgb_pwm_channel per output.
module rgb_led_pwm
    import rgb_led_pkg::*;
#(
    parameter int NUM_CH            = 3,
    parameter int PWM_BITS          = 8,
    parameter int BLINK_HALF_CYCLES = 6000000,
    parameter int BREATHE_DIV       = 8
) (
    input  logic          clk,
    input  logic          rst,
    rgb_led_pwm_if.slave  bus
);

    localparam int CH_W    = cnt_width(NUM_CH);
    localparam int BLINK_W = cnt_width(BLINK_HALF_CYCLES);
    localparam int DIV_W   = cnt_width(BREATHE_DIV);

    localparam logic [PWM_BITS-1:0] LVL_ONE  = PWM_BITS'(1);
    localparam logic [PWM_BITS-1:0] LVL_TOP  = '1;
    localparam logic [PWM_BITS-1:0] LVL_PEAK = LVL_TOP - LVL_ONE;
    localparam logic [BLINK_W-1:0]  BLINK_LAST = BLINK_W'(BLINK_HALF_CYCLES - 1);
    localparam logic [BLINK_W-1:0]  BLINK_ONE  = BLINK_W'(1);
    localparam logic [DIV_W-1:0]    DIV_LAST   = DIV_W'(BREATHE_DIV - 1);
    localparam logic [DIV_W-1:0]    DIV_ONE    = DIV_W'(1);

    logic [PWM_BITS-1:0] cnt_q, cnt_d;
    logic                period_start_q, period_start_d;
    logic [BLINK_W-1:0]  blink_cnt_q, blink_cnt_d;
    logic                blink_on_q, blink_on_d;
    logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
    logic [PWM_BITS-1:0] level_q, level_d;
    dir_t                dir_q, dir_d;
    logic                boundary;
    logic [NUM_CH-1:0]   pwm_w;

    assign boundary = (cnt_q == LVL_TOP);

    always_comb begin
        cnt_d          = cnt_q + LVL_ONE;
        period_start_d = (cnt_q == '0);
        blink_cnt_d    = blink_cnt_q + BLINK_ONE;
        blink_on_d     = blink_on_q;
        if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            blink_on_d  = ~blink_on_q;
        end
    end

    // Breathe ramp steps only on boundaries so a level never changes mid-period;
    // the direction flips on arrival at either end so the ramp never wraps.
    always_comb begin
        div_cnt_d = div_cnt_q;
        level_d   = level_q;
        dir_d     = dir_q;
        if (boundary) begin
            if (div_cnt_q == DIV_LAST) begin
                div_cnt_d = '0;
                if (dir_q == DIR_UP) begin
                    if (level_q != LVL_TOP) begin
                        level_d = level_q + LVL_ONE;
                    end
                    if (level_q >= LVL_PEAK) begin
                        dir_d = DIR_DOWN;
                    end
                end else begin
                    if (level_q != '0) begin
                        level_d = level_q - LVL_ONE;
                    end
                    if (level_q <= LVL_ONE) begin
                        dir_d = DIR_UP;
                    end
                end
            end else begin
                div_cnt_d = div_cnt_q + DIV_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q          <= '0;
            period_start_q <= 1'b0;
            blink_cnt_q    <= '0;
            blink_on_q     <= 1'b0;
            div_cnt_q      <= '0;
            level_q        <= '0;
            dir_q          <= DIR_UP;
        end else begin
            cnt_q          <= cnt_d;
            period_start_q <= period_start_d;
            blink_cnt_q    <= blink_cnt_d;
            blink_on_q     <= blink_on_d;
            div_cnt_q      <= div_cnt_d;
            level_q        <= level_d;
            dir_q          <= dir_d;
        end
    end

    // Out-of-range channel numbers match no instance and are dropped.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        rgb_pwm_channel #(
            .PWM_BITS (PWM_BITS)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .boundary_i (boundary),
            .we_i       (bus.cfg_we && (bus.cfg_ch == CH_W'(g))),
            .mode_i     (bus.cfg_mode),
            .duty_i     (bus.cfg_duty),
            .cnt_i      (cnt_q),
            .blink_on_i (blink_on_q),
            .level_i    (level_q),
            .pwm_o      (pwm_w[g])
        );
    end

    assign bus.pwm          = pwm_w;
    assign bus.period_start = period_start_q;

endmodule
